// File: rtl/vsq_pkg.sv
// Shared types, default widths and saturation helpers for the VSQ scale accumulator.
package vsq_pkg;

    localparam int unsigned DEF_LANES  = 4;
    localparam int unsigned DEF_PSUM_W = 14;
    localparam int unsigned DEF_SF_W   = 8;
    localparam int unsigned DEF_ACC_W  = 32;
    localparam int unsigned DEF_LEN_W  = 8;
    localparam int unsigned PROD_W     = DEF_PSUM_W + 2 * DEF_SF_W;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    // Product width for an arbitrary build.
    function automatic int unsigned prod_w(input int unsigned psum_w, input int unsigned sf_w);
        return psum_w + 2 * sf_w;
    endfunction

    // Largest / smallest signed ACC_W value, right-aligned in 64 bits.
    function automatic logic [63:0] acc_max(input int unsigned acc_w);
        return (64'd1 << (acc_w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] acc_min(input int unsigned acc_w);
        return ~acc_max(acc_w);
    endfunction

    localparam logic [DEF_ACC_W-1:0] ACC_MAX = DEF_ACC_W'(acc_max(DEF_ACC_W));
    localparam logic [DEF_ACC_W-1:0] ACC_MIN = DEF_ACC_W'(acc_min(DEF_ACC_W));

endpackage

// File: rtl/vsq_lane.sv
// One lane: S1 operand/scale register, S2 exact product, S3 saturating accumulator.
module vsq_lane
    import vsq_pkg::*;
#(
    parameter int unsigned PSUM_W = DEF_PSUM_W,
    parameter int unsigned SF_W   = DEF_SF_W,
    parameter int unsigned ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s1_en,
    input  logic              s3_en,
    input  logic              clr,
    input  logic              vsq,
    input  logic [PSUM_W-1:0] psum,
    input  logic [SF_W-1:0]   a_sf,
    input  logic [SF_W-1:0]   b_sf,
    output logic [ACC_W-1:0]  acc,
    output logic              sat
);

    localparam int unsigned S_W  = 2 * SF_W;
    localparam int unsigned P_W  = prod_w(PSUM_W, SF_W);
    localparam int unsigned EXT  = ACC_W + 1 - P_W;
    localparam logic [ACC_W-1:0] SAT_HI = ACC_W'(acc_max(ACC_W));
    localparam logic [ACC_W-1:0] SAT_LO = ACC_W'(acc_min(ACC_W));

    logic [PSUM_W-1:0]       psum_q;
    logic [S_W-1:0]          s_q;
    logic [S_W-1:0]          s_c;
    logic signed [P_W-1:0]   p_c;
    logic signed [P_W-1:0]   p_q;
    logic [ACC_W:0]          sum_c;
    logic                    ovf_c;
    logic [ACC_W-1:0]        acc_q;
    logic                    sat_q;

    always_comb begin
        s_c = vsq ? (S_W'(a_sf) * S_W'(b_sf)) : S_W'(1);
    end

    // Scale is zero-extended so the signed multiply treats it as unsigned; result fits P_W exactly.
    always_comb begin
        p_c = $signed({{(P_W - PSUM_W){psum_q[PSUM_W-1]}}, psum_q})
            * $signed({{(P_W - S_W){1'b0}}, s_q});
    end

    always_comb begin
        sum_c = {acc_q[ACC_W-1], acc_q} + {{EXT{p_q[P_W-1]}}, p_q};
        ovf_c = sum_c[ACC_W] ^ sum_c[ACC_W-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psum_q <= '0;
            s_q    <= '0;
            p_q    <= '0;
            acc_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            if (s1_en) begin
                psum_q <= psum;
                s_q    <= s_c;
            end
            p_q <= p_c;
            if (clr) begin
                acc_q <= '0;
                sat_q <= 1'b0;
            end else if (s3_en) begin
                if (ovf_c) begin
                    acc_q <= sum_c[ACC_W] ? SAT_LO : SAT_HI;
                    sat_q <= 1'b1;
                end else begin
                    acc_q <= sum_c[ACC_W-1:0];
                end
            end
        end
    end

    assign acc = acc_q;
    assign sat = sat_q;

endmodule

// File: rtl/vsq_scale_accum.sv
// Multi-lane VSQ accumulator: group FSM, beat counter, config latches and handshakes.
module vsq_scale_accum
    import vsq_pkg::*;
#(
    parameter int unsigned LANES  = DEF_LANES,
    parameter int unsigned PSUM_W = DEF_PSUM_W,
    parameter int unsigned SF_W   = DEF_SF_W,
    parameter int unsigned ACC_W  = DEF_ACC_W,
    parameter int unsigned LEN_W  = DEF_LEN_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_vsq,
    input  logic [LEN_W-1:0]        cfg_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*PSUM_W-1:0] in_psum,
    input  logic [LANES*SF_W-1:0]   in_a_sf,
    input  logic [SF_W-1:0]         in_b_sf,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*ACC_W-1:0]  out_acc,
    output logic [LANES-1:0]        out_sat,
    output logic                    busy
);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q;
    logic               vsq_q;
    logic               v1_q, v2_q;
    logic               in_ready_q, out_valid_q, busy_q;

    logic               accept_c, first_c, last_c, done_c, vsq_eff_c;
    logic [LEN_W-1:0]   len_eff_c;

    // Config is taken live on the first beat and from the latches afterwards.
    always_comb begin
        accept_c  = in_valid && in_ready_q;
        first_c   = (cnt_q == '0);
        len_eff_c = first_c ? ((cfg_len == '0) ? LEN_W'(1) : cfg_len) : len_q;
        vsq_eff_c = first_c ? cfg_vsq : vsq_q;
        last_c    = (cnt_q == len_eff_c - LEN_W'(1));
        done_c    = out_valid_q && out_ready;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_ACC: begin
                if (accept_c) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (last_c) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!v1_q && !v2_q) state_d = ST_OUT;
            end
            ST_OUT: begin
                if (done_c) begin
                    state_d = ST_ACC;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            cnt_q       <= '0;
            len_q       <= LEN_W'(1);
            vsq_q       <= 1'b0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            if (accept_c && first_c) begin
                len_q <= len_eff_c;
                vsq_q <= cfg_vsq;
            end
            v1_q        <= accept_c;
            v2_q        <= v1_q;
            in_ready_q  <= (state_d == ST_ACC);
            out_valid_q <= (state_d == ST_OUT);
            busy_q      <= (state_d != ST_ACC) || (cnt_d != '0) || accept_c || v1_q;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : gen_lane
        vsq_lane #(
            .PSUM_W (PSUM_W),
            .SF_W   (SF_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .s1_en  (accept_c),
            .s3_en  (v2_q),
            .clr    (done_c),
            .vsq    (vsq_eff_c),
            .psum   (in_psum[i*PSUM_W +: PSUM_W]),
            .a_sf   (in_a_sf[i*SF_W +: SF_W]),
            .b_sf   (in_b_sf),
            .acc    (out_acc[i*ACC_W +: ACC_W]),
            .sat    (out_sat[i])
        );
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_vsq_scale_accum.sv
// Scoreboard bench for vsq_scale_accum: directed groups, expected totals queued at issue.
module tb_vsq_scale_accum;

    localparam int unsigned LANES  = 4;
    localparam int unsigned PSUM_W = 14;
    localparam int unsigned SF_W   = 8;
    localparam int unsigned ACC_W  = 32;
    localparam int unsigned LEN_W  = 8;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    cfg_vsq = 1'b0;
    logic [LEN_W-1:0]        cfg_len = '0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [LANES*PSUM_W-1:0] in_psum = '0;
    logic [LANES*SF_W-1:0]   in_a_sf = '0;
    logic [SF_W-1:0]         in_b_sf = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic [LANES*ACC_W-1:0]  out_acc;
    logic [LANES-1:0]        out_sat;
    logic                    busy;

    vsq_scale_accum #(
        .LANES(LANES), .PSUM_W(PSUM_W), .SF_W(SF_W), .ACC_W(ACC_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_vsq(cfg_vsq), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_psum(in_psum),
        .in_a_sf(in_a_sf), .in_b_sf(in_b_sf), .out_valid(out_valid),
        .out_ready(out_ready), .out_acc(out_acc), .out_sat(out_sat), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [LANES*ACC_W-1:0] exp_acc_q[$];
    logic [LANES-1:0]       exp_sat_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [LANES*PSUM_W-1:0] pk_ps(input int p0, input int p1, input int p2, input int p3);
        return {PSUM_W'(p3), PSUM_W'(p2), PSUM_W'(p1), PSUM_W'(p0)};
    endfunction

    function automatic logic [LANES*SF_W-1:0] pk_sf(input int s0, input int s1, input int s2, input int s3);
        return {SF_W'(s3), SF_W'(s2), SF_W'(s1), SF_W'(s0)};
    endfunction

    function automatic logic [LANES*ACC_W-1:0] pk_acc(input int a0, input int a1, input int a2, input int a3);
        return {ACC_W'(a3), ACC_W'(a2), ACC_W'(a1), ACC_W'(a0)};
    endfunction

    task automatic expect_group(input logic [LANES*ACC_W-1:0] acc, input logic [LANES-1:0] sat);
        exp_acc_q.push_back(acc);
        exp_sat_q.push_back(sat);
    endtask

    task automatic send_beat(input logic vsq, input logic [LEN_W-1:0] len,
                             input logic [LANES*PSUM_W-1:0] ps,
                             input logic [LANES*SF_W-1:0] a, input logic [SF_W-1:0] b);
        @(negedge clk);
        cfg_vsq  = vsq;
        cfg_len  = len;
        in_psum  = ps;
        in_a_sf  = a;
        in_b_sf  = b;
        in_valid = 1'b1;
        @(posedge clk);
    endtask

    // Cycles from the last accepted beat to out_valid, sampled on negedges; -1 on timeout.
    task automatic wait_out(output int cyc);
        cyc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_psum  = LANES*PSUM_W'({$urandom(), $urandom()});
            cfg_len  = LEN_W'($urandom());
            if (out_valid) return;
            cyc++;
        end
        n_vec++;
        n_err++;
        $display("FAIL out_valid timeout: got no result, expected one within 40 cycles");
        cyc = -1;
    endtask

    // Monitor: every output transfer is checked against the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_acc_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected result: got acc %0h, expected no transfer", out_acc);
                end else begin
                    check("out_acc", 128'(out_acc), 128'(exp_acc_q.pop_front()));
                    check("out_sat", 128'(out_sat), 128'(exp_sat_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end of run");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst in_ready",  128'(in_ready),  128'(1));
        check("rst out_valid", 128'(out_valid), 128'(0));
        check("rst out_acc",   128'(out_acc),   128'(0));
        check("rst out_sat",   128'(out_sat),   128'(0));
        check("rst busy",      128'(busy),      128'(0));
        rst_n = 1'b1;

        // Plain mode: scales must be ignored.
        expect_group(pk_acc(57, 0, 0, 6), 4'b0000);
        send_beat(1'b0, 8'd3, pk_ps(100, 0, 0, 1), pk_sf(3, 3, 3, 3), 8'd5);
        send_beat(1'b0, 8'd3, pk_ps(-50, 0, 0, 2), pk_sf(3, 3, 3, 3), 8'd5);
        send_beat(1'b0, 8'd3, pk_ps(7, 0, 0, 3),   pk_sf(3, 3, 3, 3), 8'd5);
        wait_out(cyc);
        check("latency len3", 128'(cyc), 128'(3));
        @(negedge clk);
        check("post-xfer out_valid", 128'(out_valid), 128'(0));
        check("post-xfer in_ready",  128'(in_ready),  128'(1));
        check("post-xfer busy",      128'(busy),      128'(0));

        // VSQ mode: lane1 = 8191*65025 - 2*255 = 532619265.
        expect_group(pk_acc(1530, 532619265, -1275, 0), 4'b0000);
        send_beat(1'b1, 8'd2, pk_ps(2, 8191, -3, 0), pk_sf(3, 255, 1, 0), 8'd255);
        send_beat(1'b1, 8'd2, pk_ps(0, -1, -1, 0),   pk_sf(0, 2, 2, 0),   8'd255);
        wait_out(cyc);
        @(negedge clk);

        // Saturation both ways on the 5th beat; lane2 stays in range.
        expect_group(pk_acc(32'sh7FFF_FFFF, 32'sh8000_0000, 1275, 0), 4'b0011);
        for (int k = 0; k < 5; k++)
            send_beat(1'b1, 8'd5, pk_ps(8191, -8192, 1, 0), pk_sf(255, 255, 1, 0), 8'd255);
        wait_out(cyc);
        @(negedge clk);

        // Mid-group config change ignored; sat flags cleared from previous group.
        expect_group(pk_acc(30, 0, 0, 0), 4'b0000);
        send_beat(1'b0, 8'd2, pk_ps(10, 0, 0, 0), pk_sf(2, 2, 2, 2), 8'd2);
        send_beat(1'b1, 8'd7, pk_ps(20, 0, 0, 0), pk_sf(2, 2, 2, 2), 8'd2);
        wait_out(cyc);
        @(negedge clk);

        // cfg_len = 0 acts as one beat; most negative psum.
        expect_group(pk_acc(-8192, 0, 0, 0), 4'b0000);
        send_beat(1'b0, 8'd0, pk_ps(-8192, 0, 0, 0), pk_sf(9, 9, 9, 9), 8'd9);
        wait_out(cyc);
        check("latency len0", 128'(cyc), 128'(3));
        @(negedge clk);

        // Backpressure: result held 10 cycles, stray input beats ignored.
        @(posedge clk);
        #1 out_ready = 1'b0;
        expect_group(pk_acc(42, 0, 0, -1), 4'b0000);
        send_beat(1'b0, 8'd1, pk_ps(42, 0, 0, -1), pk_sf(1, 1, 1, 1), 8'd1);
        wait_out(cyc);
        in_valid = 1'b1;
        in_psum  = pk_ps(1000, 1000, 1000, 1000);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp out_valid", 128'(out_valid), 128'(1));
            check("bp in_ready",  128'(in_ready),  128'(0));
            check("bp out_acc",   128'(out_acc),   128'(pk_acc(42, 0, 0, -1)));
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp release in_ready",  128'(in_ready),  128'(1));
        check("bp release out_valid", 128'(out_valid), 128'(0));

        // Reset after 2 of 5 beats discards the partial group.
        send_beat(1'b0, 8'd5, pk_ps(11, 0, 0, 0), pk_sf(1, 1, 1, 1), 8'd1);
        send_beat(1'b0, 8'd5, pk_ps(12, 0, 0, 0), pk_sf(1, 1, 1, 1), 8'd1);
        repeat (3) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        check("mid-group busy", 128'(busy), 128'(1));
        rst_n = 1'b0;
        #1;
        check("mid-rst in_ready",  128'(in_ready),  128'(1));
        check("mid-rst out_valid", 128'(out_valid), 128'(0));
        check("mid-rst out_acc",   128'(out_acc),   128'(0));
        check("mid-rst out_sat",   128'(out_sat),   128'(0));
        check("mid-rst busy",      128'(busy),      128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        expect_group(pk_acc(5, 0, 0, 0), 4'b0000);
        send_beat(1'b0, 8'd1, pk_ps(5, 0, 0, 0), pk_sf(1, 1, 1, 1), 8'd1);
        wait_out(cyc);
        check("latency post-rst", 128'(cyc), 128'(3));
        @(negedge clk);
        @(negedge clk);

        check("scoreboard drained", 128'(exp_acc_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
